// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects N active-low push-buttons, plus hold-to-repeat.
// Define BTN_CONDITIONER_AUTO_REPEAT_EN to build the repeat FSM; otherwise rpt is a copy of press.
module btn_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_n,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] rpt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]    sync_p0;
    logic [N-1:0]    sync_p1;
    logic [N-1:0]    pushed;
    logic [N-1:0]    toggle;
    logic [N-1:0]    rise;
    logic [N-1:0]    fall;
    logic [DB_W-1:0] db_cnt [N];

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // Stage p0/p1: two-flop synchronizer, idling at the released pin level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pushed = ~sync_p1;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N; i++) begin
            toggle[i] = (pushed[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign rise = toggle & ~level;
    assign fall = toggle & level;

    // Stage p2: debounce counters; level and its edge pulses change on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < N; i++) db_cnt[i] <= '0;
        end else begin
            level         <= level ^ toggle;
            press         <= rise;
            release_pulse <= fall;
            for (int i = 0; i < N; i++) begin
                if ((pushed[i] == level[i]) || toggle[i]) db_cnt[i] <= '0;
                else                                      db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    rpt_state_t       state      [N];
    rpt_state_t       state_next [N];
    logic [RPT_W-1:0] rpt_cnt    [N];
    logic [RPT_W-1:0] cnt_next   [N];
    logic [N-1:0]     rpt_set;

    // Stage p2: repeat FSM consumes the same-cycle rise/fall so rpt lines up with press
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt <= '0;
            for (int i = 0; i < N; i++) begin
                state[i]   <= IDLE;
                rpt_cnt[i] <= '0;
            end
        end else begin
            rpt <= rpt_set;
            for (int i = 0; i < N; i++) begin
                state[i]   <= state_next[i];
                rpt_cnt[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_next[i] = state[i];
            if (fall[i]) begin
                state_next[i] = IDLE;
            end else begin
                case (state[i])
                    IDLE:    if (rise[i]) state_next[i] = DELAY;
                    DELAY:   if (rpt_cnt[i] == DELAY_LAST) state_next[i] = REPEAT;
                    REPEAT:  state_next[i] = REPEAT;
                    default: state_next[i] = IDLE;
                endcase
            end
        end
    end

    // A falling level suppresses any expiry on the same edge
    always_comb begin
        rpt_set = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
            if (!fall[i]) begin
                case (state[i])
                    IDLE: rpt_set[i] = rise[i];
                    DELAY: begin
                        if (rpt_cnt[i] == DELAY_LAST) rpt_set[i]  = 1'b1;
                        else                          cnt_next[i] = rpt_cnt[i] + 1'b1;
                    end
                    REPEAT: begin
                        if (rpt_cnt[i] == PERIOD_LAST) rpt_set[i]  = 1'b1;
                        else                           cnt_next[i] = rpt_cnt[i] + 1'b1;
                    end
                    default: rpt_set[i] = 1'b0;
                endcase
            end
        end
    end
`else
    assign rpt = press;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (N=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5).
// Expected repeat pulses follow BTN_CONDITIONER_AUTO_REPEAT_EN as seen by this build.
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int P  = DB + 1;   // edge at which level first rises after a pin change at edge 0

`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;
    logic [N-1:0] rpt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4*N-1:0] exp_q [$];

    always #5 clk = ~clk;

    btn_conditioner #(
        .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n),
        .level(level), .press(press), .release_pulse(release_pulse), .rpt(rpt)
    );

    function automatic logic [4*N-1:0] pack(input logic [N-1:0] l, input logic [N-1:0] p,
                                            input logic [N-1:0] r, input logic [N-1:0] t);
        return {l, p, r, t};
    endfunction

    // Repeat schedule for a press whose level rose at edge rise_c and is still up at edge c
    function automatic bit rpt_due(input int c, input int rise_c, input int fall_c);
        if (c == rise_c) return 1'b1;
        if (!AUTO_RPT) return 1'b0;
        if (c < rise_c + RD || c >= fall_c) return 1'b0;
        return ((c - rise_c - RD) % RP) == 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        btn_n = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4*N-1:0] e, obs;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            btn_n = '0;
            exp_q.push_back(pack('0, '0, '0, '0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] b, l, p, r, t;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            b = '1; b[0] = 1'b0;
            l = '0; p = '0; r = '0; t = '0;
            l[0] = (c >= P);
            p[0] = (c == P);
            t[0] = rpt_due(c, P, 1000);
            btn_n = b;
            exp_q.push_back(pack(l, p, r, t));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL clean_press c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] b;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            b = '1;
            b[1] = !((c < 3) || (c >= 5 && c < 8));
            btn_n = b;
            exp_q.push_back(pack('0, '0, '0, '0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL bounce c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] b, l, p, r, t;
        int fall_c;
        fall_c = 58 + P;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            b = '1; b[2] = (c >= 58);
            l = '0; p = '0; r = '0; t = '0;
            l[2] = (c >= P) && (c < fall_c);
            p[2] = (c == P);
            r[2] = (c == fall_c);
            t[2] = rpt_due(c, P, fall_c);
            btn_n = b;
            exp_q.push_back(pack(l, p, r, t));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL auto_repeat c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    // Fall at edge 40 lands on a period expiry (5+20+3*5); the later re-press proves the FSM went idle
    task automatic test_release_vs_expiry();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] b, l, p, r, t;
        int fall_c, rise2;
        fall_c = 35 + P;
        rise2  = 50 + P;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            b = '1; b[3] = (c >= 35 && c < 50);
            l = '0; p = '0; r = '0; t = '0;
            l[3] = ((c >= P) && (c < fall_c)) || (c >= rise2);
            p[3] = (c == P) || (c == rise2);
            r[3] = (c == fall_c);
            t[3] = (c < rise2) ? rpt_due(c, P, fall_c) : rpt_due(c, rise2, 1000);
            btn_n = b;
            exp_q.push_back(pack(l, p, r, t));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL release_vs_expiry c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] b, l, p, r, t;
        int rst_c, rise2;
        rst_c = P + 22;
        rise2 = rst_c + 1 + P;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            b = '1; b[0] = 1'b0;
            l = '0; p = '0; r = '0; t = '0;
            l[0] = ((c >= P) && (c < rst_c)) || (c >= rise2);
            p[0] = (c == P) || (c == rise2);
            if (c < rst_c)       t[0] = rpt_due(c, P, 1000);
            else if (c >= rise2) t[0] = rpt_due(c, rise2, 1000);
            btn_n = b;
            reset = (c == rst_c);
            exp_q.push_back(pack(l, p, r, t));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_mid_hold c=%0d got %h expected %h", c, obs, e);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [4*N-1:0] e, obs;
        logic [N-1:0] l, p, r, t;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            l = ((c >= P) && (c < 10 + P)) ? '1 : '0;
            p = (c == P) ? '1 : '0;
            r = (c == 10 + P) ? '1 : '0;
            t = rpt_due(c, P, 10 + P) ? '1 : '0;
            btn_n = (c < 10) ? '0 : '1;
            exp_q.push_back(pack(l, p, r, t));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {level, press, release_pulse, rpt};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL simultaneous c=%0d got %h expected %h", c, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_vs_expiry();
        test_reset_mid_hold();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
